clk_div_ctrl: RTL and testbench

// Run-time controller for the CPU's divided clock: generates clk_out with a programmable half-period.

---
 rtl/clk_div_pkg.sv | 13 +
 rtl/clk_div_core.sv | 44 ++++
 rtl/clk_div_ctrl.sv | 111 +++++++++++
 tb/tb_clk_div_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock controller.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEF        = 8;
    localparam int unsigned DEFAULT_HALF_DEF = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_e;

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and clk_out toggle flop; holds the active half-period H.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W        = DIV_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             load,
    input  logic [DIV_W-1:0] half_in,
    output logic             clk_out,
    output logic             at_end
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] half_q;

    // H is never 0, so H-1 cannot wrap and cnt stays below 2^DIV_W-1.
    assign at_end = (cnt_q == half_q - DIV_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            clk_out <= 1'b0;
            half_q  <= DIV_W'(DEFAULT_HALF);
        end else begin
            if (!run) begin
                cnt_q   <= '0;
                clk_out <= 1'b0;
            end else if (at_end) begin
                cnt_q   <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt_q <= cnt_q + DIV_W'(1);
            end
            if (load) begin
                half_q <= half_in;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Divided-clock controller: run/stop FSM, ratio handshake and pending register.
// Optional CLK_DIV_CTRL_TICK_EN adds tick_out, high on the cycle clk_out becomes 1.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W        = DIV_W_DEF,
    parameter int unsigned DEFAULT_HALF = DEFAULT_HALF_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             active,
`ifdef CLK_DIV_CTRL_TICK_EN
    output logic             tick_out,
`endif
    output logic             clk_out
);

    state_e           state_q, state_d;
    logic             pend_valid_q, pend_valid_d;
    logic [DIV_W-1:0] pend_half_q, pend_half_d;
    logic             cfg_err_q, cfg_err_d;
    logic             at_end;
    logic             rise;
    logic             load;
    logic             run;
    logic             accept;

    assign accept = cfg_valid && !pend_valid_q;
    assign rise   = (state_q == RUN) && run_en && !clk_out && at_end;
    // New H takes effect only at a rising boundary so a whole period uses one H.
    assign load   = pend_valid_q && ((state_q == IDLE) || rise);
    assign run    = (state_q != IDLE) && (state_d != IDLE);

    assign cfg_ready = !pend_valid_q;
    assign cfg_err   = cfg_err_q;
    assign active    = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_half_d  = pend_half_q;
        cfg_err_d    = 1'b0;

        unique case (state_q)
            IDLE:     if (run_en) state_d = RUN;
            // Stopping while low truncates the low phase; while high, finish the pulse.
            RUN:      if (!run_en) state_d = (clk_out && !at_end) ? STOPPING : IDLE;
            STOPPING: if (at_end) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (load) begin
            pend_valid_d = 1'b0;
        end
        if (accept) begin
            if (cfg_half == '0) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_half_d  = cfg_half;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_half_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_half_q  <= pend_half_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

`ifdef CLK_DIV_CTRL_TICK_EN
    logic tick_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= rise;
        end
    end

    assign tick_out = tick_q;
`endif

    clk_div_core #(
        .DIV_W        (DIV_W),
        .DEFAULT_HALF (DEFAULT_HALF)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .load    (load),
        .half_in (pend_half_q),
        .clk_out (clk_out),
        .at_end  (at_end)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-position reference model queues expected outputs.
module tb_clk_div_ctrl;

    localparam int DIV_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             run_en = 1'b0;
    logic             cfg_valid = 1'b0;
    logic [DIV_W-1:0] cfg_half = '0;
    logic             cfg_ready;
    logic             cfg_err;
    logic             active;
    logic             clk_out;
`ifdef CLK_DIV_CTRL_TICK_EN
    logic             tick_out;
`endif

    clk_div_ctrl #(
        .DIV_W        (DIV_W),
        .DEFAULT_HALF (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .run_en    (run_en),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .active    (active),
`ifdef CLK_DIV_CTRL_TICK_EN
        .tick_out  (tick_out),
`endif
        .clk_out   (clk_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic lvl;
        logic act;
        logic rdy;
        logic err;
        logic tick;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: mode 0 idle, 1 running, 2 stopping. Position p within a 2H
    // period counted from a rising edge; output is high while p < H. Entry starts at p=H.
    int m_mode, m_p, m_h, m_pv, m_pval, m_err, m_tick;

    task automatic check(input string name, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0b want %0b at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_p = 0; m_h = 2; m_pv = 0; m_pval = 0; m_err = 0; m_tick = 0;
    endtask

    task automatic model_edge();
        logic lvl;
        logic acc;
        exp_t e;
        lvl = (m_mode != 0) && (m_p < m_h);
        acc = cfg_valid && (m_pv == 0);
        m_err = 0;
        m_tick = 0;
        case (m_mode)
            0: begin
                if (m_pv != 0) begin m_h = m_pval; m_pv = 0; end
                if (run_en) begin m_mode = 1; m_p = m_h; end
            end
            1: begin
                if (!run_en && !lvl) begin
                    m_mode = 0;
                end else begin
                    m_p++;
                    if (!run_en) begin
                        m_mode = (m_p == m_h) ? 0 : 2;
                    end else if (m_p == 2 * m_h) begin
                        m_p = 0;
                        m_tick = 1;
                        if (m_pv != 0) begin m_h = m_pval; m_pv = 0; end
                    end
                end
            end
            default: begin
                m_p++;
                if (m_p == m_h) m_mode = 0;
            end
        endcase
        if (acc) begin
            if (cfg_half == 0) m_err = 1;
            else begin m_pv = 1; m_pval = int'(cfg_half); end
        end
        e.lvl  = (m_mode != 0) && (m_p < m_h);
        e.act  = (m_mode != 0);
        e.rdy  = (m_pv == 0);
        e.err  = (m_err != 0);
        e.tick = (m_tick != 0);
        exp_q.push_back(e);
    endtask

    // One clock: the model consumes the inputs sampled at this edge, then new ones are driven.
    task automatic cyc(input logic r, input logic v, input int half);
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        run_en    = r;
        cfg_valid = v;
        cfg_half  = DIV_W'(half);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_clk_out"}, clk_out, 1'b0);
        check({tag, "_active"}, active, 1'b0);
        check({tag, "_cfg_ready"}, cfg_ready, 1'b1);
        check({tag, "_cfg_err"}, cfg_err, 1'b0);
`ifdef CLK_DIV_CTRL_TICK_EN
        check({tag, "_tick"}, tick_out, 1'b0);
`endif
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check_reset_vals("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("clk_out", clk_out, e.lvl);
            check("active", active, e.act);
            check("cfg_ready", cfg_ready, e.rdy);
            check("cfg_err", cfg_err, e.err);
`ifdef CLK_DIV_CTRL_TICK_EN
            check("tick_out", tick_out, e.tick);
`endif
        end
    end

    initial begin
        int r;
        int half;
        model_reset();
        #1;
        check_reset_vals("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        run_en = 1'b1;

        // Start from reset with H=2.
        repeat (12) cyc(1'b1, 1'b0, 0);

        // Ratio change mid-period takes effect at the next rising boundary.
        cyc(1'b1, 1'b1, 5);
        repeat (30) cyc(1'b1, 1'b0, 0);

        // Stop one cycle into a high phase; run_en pulse during STOPPING is ignored.
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 0);
            if (m_mode == 1 && m_p == 1) break;
        end
        cyc(1'b0, 1'b0, 0);
        cyc(1'b1, 1'b0, 0);
        repeat (12) cyc(1'b0, 1'b0, 0);

        // Zero ratio is rejected.
        cyc(1'b0, 1'b1, 0);
        repeat (3) cyc(1'b0, 1'b0, 0);
        repeat (24) cyc(1'b1, 1'b0, 0);

        // Reset during a high phase with a pending config.
        cyc(1'b1, 1'b1, 7);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 0);
            if (m_mode == 1 && m_p == 1 && m_pv != 0) break;
        end
        do_reset();
        repeat (12) cyc(1'b1, 1'b0, 0);

        // H=1, divide-by-2.
        cyc(1'b1, 1'b1, 1);
        repeat (16) cyc(1'b1, 1'b0, 0);

        // Randomized traffic including H=255 and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 7));
            if (r == 7 && $urandom_range(0, 3) == 0) half = 255;
            else if (r == 0) half = 0;
            else half = int'($urandom_range(1, 6));
            cyc(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) == 0), half);
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        cyc(1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
